// File: rtl/data_sram_slave.sv
// Word-addressed SRAM slave with a 2-deep in-order request queue and a configurable number of wait states.
// Responses (data_data_ok) are issued in ACCESS. The memory access happens on the clock edge that enters ACCESS.
module data_sram_slave #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [2:0]  data_size,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic [31:0] data_rdata,
    output logic        data_data_ok,
    output logic [1:0]  outstanding
);

    typedef struct packed {
        logic              wr;
        logic [3:0]        wstrb;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
    } req_t;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    state_t      state, state_nxt;
    logic [3:0]  wcnt, wcnt_nxt;
    req_t        fifo [2];
    req_t        in_req, head;
    logic        rd_ptr, wr_ptr;
    logic        accept, pop, go;
    logic [1:0]  avail;
    logic [31:0] mem [1<<ADDR_W];
    logic        unused_bits;

    assign unused_bits  = ^{data_size, data_addr[1:0], data_addr[31:ADDR_W+2]};

    assign data_addr_ok = resetn && (outstanding < 2'd2);
    assign accept       = data_req && data_addr_ok;
    assign pop          = (state == ACCESS);
    assign data_data_ok = (state == ACCESS);
    assign in_req       = {data_wr, data_wstrb, data_addr[ADDR_W+1:2], data_wdata};

    // Entries still waiting once the current ACCESS pops its head.
    // An empty queue means the request arriving this cycle is next.
    assign avail = outstanding - {1'b0, pop};
    assign head  = (avail != 2'd0) ? fifo[rd_ptr ^ pop] : in_req;

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            IDLE, ACCESS: begin
                if (avail != 2'd0 || accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = ACCESS;
                    end else begin
                        state_nxt = WAIT;
                        wcnt_nxt  = 4'(WAIT_CYCLES - 1);
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (wcnt == 4'd0) state_nxt = ACCESS;
                else              wcnt_nxt  = wcnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign go = (state_nxt == ACCESS);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            wcnt        <= 4'd0;
            outstanding <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            data_rdata  <= 32'd0;
        end else begin
            state       <= state_nxt;
            wcnt        <= wcnt_nxt;
            outstanding <= outstanding + {1'b0, accept} - {1'b0, pop};
            if (accept) wr_ptr <= ~wr_ptr;
            if (pop)    rd_ptr <= ~rd_ptr;
            if (go)     data_rdata <= head.wr ? 32'd0 : mem[head.addr];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) fifo[wr_ptr] <= in_req;
    end

    // Queue and memory contents are not reset. A write that is still queued at reset is dropped.
    always_ff @(posedge clk) begin
        if (resetn && go && head.wr) begin
            for (int i = 0; i < 4; i++)
                if (head.wstrb[i]) mem[head.addr][8*i +: 8] <= head.wdata[8*i +: 8];
        end
    end

endmodule
